// File: rtl/dff_pipe_sync_reset_if.sv
// ---------------------------------------------------------------------------
// dff_pipe_sync_reset_if
//   Bundles the data-side and reset-status signals of dff_pipe_sync_reset.
//
//   Signals
//     data      WIDTH  input data toward the pipeline
//     data_vld  1      qualifier for data; stage 0 loads only when high
//     q         WIDTH  output of the last pipeline stage
//     q_vld     1      valid bit of the last pipeline stage
//     rst_out   1      conditioned (synchronised + stretched) reset, active-high
//     rst_done  1      one-cycle pulse marking the end of a conditioned reset
//
//   Modports
//     master  : the side that produces data and consumes q / reset status
//     slave   : the pipeline block itself
// ---------------------------------------------------------------------------
interface dff_pipe_sync_reset_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic [WIDTH-1:0] data;
  logic             data_vld;
  logic [WIDTH-1:0] q;
  logic             q_vld;
  logic             rst_out;
  logic             rst_done;

  modport master (
    output data,
    output data_vld,
    input  q,
    input  q_vld,
    input  rst_out,
    input  rst_done
  );

  modport slave (
    input  data,
    input  data_vld,
    output q,
    output q_vld,
    output rst_out,
    output rst_done
  );

endinterface

// File: rtl/dff_pipe_sync_reset.sv
// ---------------------------------------------------------------------------
// dff_pipe_sync_reset
//   Reset-conditioned register pipeline. The raw synchronous reset is passed
//   through a SYNC_STAGES shift chain and then stretched by MIN_RST_CYCLES
//   extra cycles. The resulting conditioned reset (rst_out) clears a
//   DEPTH-stage, WIDTH-bit data pipeline that carries a valid bit per stage.
//
//   Parameters
//     WIDTH           data width (>=1)
//     DEPTH           number of pipeline stages (>=1)
//     RST_VAL         value loaded into every data stage on reset
//     SYNC_STAGES     reset chain length (>=2)
//     MIN_RST_CYCLES  extra hold cycles after the chain deasserts (>=0)
//
//   Ports
//     clk    in  sole clock, all state updates on posedge
//     reset  in  synchronous, active-high raw reset
//     bus    slave modport of dff_pipe_sync_reset_if:
//              data/data_vld in, q/q_vld/rst_out/rst_done out
//
//   Timing (reset sampled low at edge m, no re-assert)
//     rst_out falls after edge m+SYNC_STAGES-1+MIN_RST_CYCLES and rst_done
//     pulses for one cycle after the edge following that.
// ---------------------------------------------------------------------------
module dff_pipe_sync_reset #(
  parameter int unsigned      WIDTH          = 8,
  parameter int unsigned      DEPTH          = 2,
  parameter logic [WIDTH-1:0] RST_VAL        = {WIDTH{1'b0}},
  parameter int unsigned      SYNC_STAGES    = 2,
  parameter int unsigned      MIN_RST_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  dff_pipe_sync_reset_if.slave  bus
);

  // Counter must be at least one bit wide even when no stretch is requested.
  localparam int unsigned     CNT_W_RAW = $clog2(MIN_RST_CYCLES + 1);
  localparam int unsigned     CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MIN_RST_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);

  // Reset conditioning state
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   rst_prev_q;
  logic                   rst_prev_d;
  logic                   rst_done_q;
  logic                   rst_done_d;
  logic                   rst_out_s;

  // Data pipeline state
  logic [DEPTH-1:0][WIDTH-1:0] data_q;
  logic [DEPTH-1:0][WIDTH-1:0] data_d;
  logic [DEPTH-1:0]            vld_q;
  logic [DEPTH-1:0]            vld_d;

  // Conditioned reset: OR of registers only, so it cannot glitch while the
  // chain hands over to the stretch counter (counter reloads while the chain
  // tail is still high).
  assign rst_out_s = sync_q[SYNC_STAGES-1] | (cnt_q != CNT_ZERO);

  // Next state of the reset chain: shift a zero in from stage 0
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], 1'b0};
  end

  // Next state of the stretch counter: reload while the chain tail is high,
  // then count down to zero
  always_comb begin
    cnt_d = cnt_q;
    if (sync_q[SYNC_STAGES-1]) begin
      cnt_d = CNT_LOAD;
    end else if (cnt_q != CNT_ZERO) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Next state of the release detector: rst_done fires one cycle after the
  // first low cycle of rst_out, using the previous-cycle copy of rst_out
  always_comb begin
    rst_prev_d = rst_out_s;
    rst_done_d = rst_prev_q & ~rst_out_s;
  end

  // Reset conditioning registers; raw reset fills the chain and reloads the
  // counter, and forces rst_done low from the first reset edge
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= {SYNC_STAGES{1'b1}};
      cnt_q      <= CNT_LOAD;
      rst_prev_q <= 1'b1;
      rst_done_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      cnt_q      <= cnt_d;
      rst_prev_q <= rst_prev_d;
      rst_done_q <= rst_done_d;
    end
  end

  // Next state of the data pipeline: clear while rst_out is high, otherwise
  // stage 0 captures qualified data (holding its value when not qualified)
  // and every later stage copies its predecessor unconditionally
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (rst_out_s) begin
      data_d = {DEPTH{RST_VAL}};
      vld_d  = {DEPTH{1'b0}};
    end else begin
      if (bus.data_vld) begin
        data_d[0] = bus.data;
      end else begin
        data_d[0] = data_q[0];
      end
      vld_d[0] = bus.data_vld;
      for (int k = 1; k < DEPTH; k++) begin
        data_d[k] = data_q[k-1];
        vld_d[k]  = vld_q[k-1];
      end
    end
  end

  // Data pipeline registers. The raw reset clears them too: rst_out only
  // rises one edge after reset is sampled, and without this a beat already
  // one stage from the output would still emerge on that edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= {DEPTH{RST_VAL}};
      vld_q  <= {DEPTH{1'b0}};
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign bus.q        = data_q[DEPTH-1];
  assign bus.q_vld    = vld_q[DEPTH-1];
  assign bus.rst_out  = rst_out_s;
  assign bus.rst_done = rst_done_q;

endmodule

// File: tb/tb_dff_pipe_sync_reset.sv
// ---------------------------------------------------------------------------
// tb_dff_pipe_sync_reset
//   Self-checking bench for dff_pipe_sync_reset. dut_a uses the default
//   parameters; dut_b uses WIDTH=16, DEPTH=4, SYNC_STAGES=3,
//   MIN_RST_CYCLES=0, RST_VAL=16'hBEEF. Expected output beats are queued
//   when driven and compared when q_vld is seen.
// ---------------------------------------------------------------------------
module tb_dff_pipe_sync_reset;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  dff_pipe_sync_reset_if #(.WIDTH(8))  bus_a ();
  dff_pipe_sync_reset_if #(.WIDTH(16)) bus_b ();

  dff_pipe_sync_reset #(
    .WIDTH(8), .DEPTH(2), .RST_VAL(8'h00), .SYNC_STAGES(2), .MIN_RST_CYCLES(4)
  ) dut_a (
    .clk(clk), .reset(rst_a), .bus(bus_a)
  );

  dff_pipe_sync_reset #(
    .WIDTH(16), .DEPTH(4), .RST_VAL(16'hBEEF), .SYNC_STAGES(3), .MIN_RST_CYCLES(0)
  ) dut_b (
    .clk(clk), .reset(rst_b), .bus(bus_b)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  sb_a[$];
  logic [15:0] sb_b[$];

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset held 3 cycles: reset state, then release timing of rst_out/rst_done
  task automatic test_reset();
    logic exp_out;
    logic exp_done;
    rst_a = 1'b1;
    bus_a.data_vld = 1'b0;
    bus_a.data = 8'h00;
    tick();
    checks++;
    if (bus_a.rst_out !== 1'b1) begin
      errors++; $display("FAIL reset_rst_out: got %b expected 1", bus_a.rst_out);
    end
    checks++;
    if (bus_a.q !== 8'h00) begin
      errors++; $display("FAIL reset_q: got %h expected 00", bus_a.q);
    end
    checks++;
    if (bus_a.q_vld !== 1'b0) begin
      errors++; $display("FAIL reset_q_vld: got %b expected 0", bus_a.q_vld);
    end
    checks++;
    if (bus_a.rst_done !== 1'b0) begin
      errors++; $display("FAIL reset_rst_done: got %b expected 0", bus_a.rst_done);
    end
    tick();
    tick();
    rst_a = 1'b0;
    for (int j = 0; j < 8; j++) begin
      tick();
      exp_out  = (j <= 4);
      exp_done = (j == 6);
      checks++;
      if (bus_a.rst_out !== exp_out) begin
        errors++; $display("FAIL release_rst_out m+%0d: got %b expected %b", j, bus_a.rst_out, exp_out);
      end
      checks++;
      if (bus_a.rst_done !== exp_done) begin
        errors++; $display("FAIL release_rst_done m+%0d: got %b expected %b", j, bus_a.rst_done, exp_done);
      end
    end
  endtask

  // One-cycle reset pulse gives exactly 6 cycles of rst_out
  task automatic test_pulse();
    int highs;
    logic exp_out;
    logic exp_done;
    highs = 0;
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    if (bus_a.rst_out === 1'b1) highs++;
    checks++;
    if (bus_a.rst_out !== 1'b1) begin
      errors++; $display("FAIL pulse_rst_out e+0: got %b expected 1", bus_a.rst_out);
    end
    for (int j = 1; j <= 8; j++) begin
      tick();
      if (bus_a.rst_out === 1'b1) highs++;
      exp_out  = (j <= 5);
      exp_done = (j == 7);
      checks++;
      if (bus_a.rst_out !== exp_out) begin
        errors++; $display("FAIL pulse_rst_out e+%0d: got %b expected %b", j, bus_a.rst_out, exp_out);
      end
      checks++;
      if (bus_a.rst_done !== exp_done) begin
        errors++; $display("FAIL pulse_rst_done e+%0d: got %b expected %b", j, bus_a.rst_done, exp_done);
      end
      checks++;
      if (bus_a.q !== 8'h00 || bus_a.q_vld !== 1'b0) begin
        errors++; $display("FAIL pulse_q e+%0d: got q=%h vld=%b expected q=00 vld=0", j, bus_a.q, bus_a.q_vld);
      end
    end
    checks++;
    if (highs != 6) begin
      errors++; $display("FAIL pulse_width: got %0d cycles expected 6", highs);
    end
  endtask

  // Single beat: appears one edge after capture, then q holds with q_vld low
  task automatic test_single();
    logic [7:0] exp8;
    bus_a.data = 8'hA5;
    bus_a.data_vld = 1'b1;
    sb_a.push_back(8'hA5);
    tick();
    bus_a.data = 8'h3C;
    bus_a.data_vld = 1'b0;
    checks++;
    if (bus_a.q_vld !== 1'b0) begin
      errors++; $display("FAIL single_early_vld: got %b expected 0", bus_a.q_vld);
    end
    tick();
    checks++;
    if (bus_a.q_vld !== 1'b1) begin
      errors++; $display("FAIL single_vld: got %b expected 1", bus_a.q_vld);
    end
    if (bus_a.q_vld === 1'b1) begin
      checks++;
      if (sb_a.size() == 0) begin
        errors++; $display("FAIL single_sb: got beat %h expected none", bus_a.q);
      end else begin
        exp8 = sb_a.pop_front();
        if (bus_a.q !== exp8) begin
          errors++; $display("FAIL single_q: got %h expected %h", bus_a.q, exp8);
        end
      end
    end
    tick();
    checks++;
    if (bus_a.q_vld !== 1'b0 || bus_a.q !== 8'hA5) begin
      errors++; $display("FAIL single_hold: got q=%h vld=%b expected q=a5 vld=0", bus_a.q, bus_a.q_vld);
    end
  endtask

  // Three contiguous beats emerge in order, contiguous, 2-cycle latency
  task automatic test_back_to_back();
    logic [7:0] exp8;
    logic exp_vld;
    for (int i = 0; i < 7; i++) begin
      if (i < 3) begin
        bus_a.data = 8'(i + 1);
        bus_a.data_vld = 1'b1;
        sb_a.push_back(8'(i + 1));
      end else begin
        bus_a.data = 8'hFF;
        bus_a.data_vld = 1'b0;
      end
      tick();
      exp_vld = (i >= 1 && i <= 3);
      checks++;
      if (bus_a.q_vld !== exp_vld) begin
        errors++; $display("FAIL b2b_vld cyc%0d: got %b expected %b", i, bus_a.q_vld, exp_vld);
      end
      if (bus_a.q_vld === 1'b1) begin
        checks++;
        if (sb_a.size() == 0) begin
          errors++; $display("FAIL b2b_sb: got beat %h expected none", bus_a.q);
        end else begin
          exp8 = sb_a.pop_front();
          if (bus_a.q !== exp8) begin
            errors++; $display("FAIL b2b_q: got %h expected %h", bus_a.q, exp8);
          end
        end
      end
    end
    checks++;
    if (sb_a.size() != 0) begin
      errors++; $display("FAIL b2b_drain: got %0d left expected 0", sb_a.size());
    end
  endtask

  // Re-assert mid-stretch while data_vld is high: no drop, one rst_done,
  // beats offered during reset are dropped
  task automatic test_reassert();
    int pulses;
    logic exp_out;
    logic exp_done;
    pulses = 0;
    rst_a = 1'b1;
    bus_a.data = 8'h77;
    bus_a.data_vld = 1'b1;
    tick();
    rst_a = 1'b0;
    for (int j = 0; j < 3; j++) begin
      if (j == 2) rst_a = 1'b1;
      tick();
      if (bus_a.rst_done === 1'b1) pulses++;
      checks++;
      if (bus_a.rst_out !== 1'b1 || bus_a.q_vld !== 1'b0) begin
        errors++; $display("FAIL reassert_pre cyc%0d: got rst_out=%b q_vld=%b expected 1/0", j, bus_a.rst_out, bus_a.q_vld);
      end
    end
    rst_a = 1'b0;
    for (int j = 0; j < 9; j++) begin
      tick();
      if (j == 0) bus_a.data_vld = 1'b0;
      if (bus_a.rst_done === 1'b1) pulses++;
      exp_out  = (j <= 4);
      exp_done = (j == 6);
      checks++;
      if (bus_a.rst_out !== exp_out) begin
        errors++; $display("FAIL reassert_rst_out m+%0d: got %b expected %b", j, bus_a.rst_out, exp_out);
      end
      checks++;
      if (bus_a.rst_done !== exp_done) begin
        errors++; $display("FAIL reassert_rst_done m+%0d: got %b expected %b", j, bus_a.rst_done, exp_done);
      end
      checks++;
      if (bus_a.q_vld !== 1'b0) begin
        errors++; $display("FAIL reassert_drop m+%0d: got q_vld=%b expected 0", j, bus_a.q_vld);
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL reassert_pulses: got %0d expected 1", pulses);
    end
  endtask

  // Reset while two beats are in flight: nothing valid ever emerges
  task automatic test_inflight();
    bus_a.data = 8'h11;
    bus_a.data_vld = 1'b1;
    tick();
    bus_a.data = 8'h22;
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    bus_a.data_vld = 1'b0;
    checks++;
    if (bus_a.q_vld !== 1'b0 || bus_a.q !== 8'h00) begin
      errors++; $display("FAIL inflight_first: got q=%h vld=%b expected q=00 vld=0", bus_a.q, bus_a.q_vld);
    end
    for (int j = 0; j < 10; j++) begin
      tick();
      checks++;
      if (bus_a.q_vld !== 1'b0 || bus_a.q !== 8'h00) begin
        errors++; $display("FAIL inflight cyc%0d: got q=%h vld=%b expected q=00 vld=0", j, bus_a.q, bus_a.q_vld);
      end
    end
  endtask

  // Alternate parameter set: RST_VAL, 2-edge release, 4-cycle latency
  task automatic test_params();
    logic [15:0] exp16;
    logic [15:0] val;
    logic exp_out;
    logic exp_done;
    logic exp_vld;
    tick();
    checks++;
    if (bus_b.q !== 16'hBEEF || bus_b.q_vld !== 1'b0 || bus_b.rst_out !== 1'b1) begin
      errors++; $display("FAIL p_reset: got q=%h vld=%b rst_out=%b expected beef/0/1", bus_b.q, bus_b.q_vld, bus_b.rst_out);
    end
    rst_b = 1'b0;
    for (int j = 0; j < 5; j++) begin
      tick();
      exp_out  = (j <= 1);
      exp_done = (j == 3);
      checks++;
      if (bus_b.rst_out !== exp_out) begin
        errors++; $display("FAIL p_rst_out m+%0d: got %b expected %b", j, bus_b.rst_out, exp_out);
      end
      checks++;
      if (bus_b.rst_done !== exp_done) begin
        errors++; $display("FAIL p_rst_done m+%0d: got %b expected %b", j, bus_b.rst_done, exp_done);
      end
    end
    for (int i = 0; i < 10; i++) begin
      if (i < 4) begin
        val = 16'($urandom);
        bus_b.data = val;
        bus_b.data_vld = 1'b1;
        sb_b.push_back(val);
      end else begin
        bus_b.data = 16'h0000;
        bus_b.data_vld = 1'b0;
      end
      tick();
      exp_vld = (i >= 3 && i <= 6);
      checks++;
      if (bus_b.q_vld !== exp_vld) begin
        errors++; $display("FAIL p_vld cyc%0d: got %b expected %b", i, bus_b.q_vld, exp_vld);
      end
      if (bus_b.q_vld === 1'b1) begin
        checks++;
        if (sb_b.size() == 0) begin
          errors++; $display("FAIL p_sb: got beat %h expected none", bus_b.q);
        end else begin
          exp16 = sb_b.pop_front();
          if (bus_b.q !== exp16) begin
            errors++; $display("FAIL p_q: got %h expected %h", bus_b.q, exp16);
          end
        end
      end
    end
    checks++;
    if (sb_b.size() != 0) begin
      errors++; $display("FAIL p_drain: got %0d left expected 0", sb_b.size());
    end
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.data = 8'h00;
    bus_a.data_vld = 1'b0;
    bus_b.data = 16'h0000;
    bus_b.data_vld = 1'b0;
    test_reset();
    test_pulse();
    test_single();
    test_back_to_back();
    test_reassert();
    test_inflight();
    test_params();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
